// File: rtl/router_switch_allocator_if.sv
// Flit handshake bundle between the five router input ports, the switch allocator
// and the five registered output ports.
interface router_switch_allocator_if;
  logic [4:0]  in_valid;
  logic [39:0] in_flit;
  logic [4:0]  in_ready;
  logic [4:0]  out_valid;
  logic [39:0] out_flit;
  logic [4:0]  out_ready;
  logic [4:0]  out_busy;

  modport master (
    output in_valid, in_flit, out_ready,
    input  in_ready, out_valid, out_flit, out_busy
  );

  modport slave (
    input  in_valid, in_flit, out_ready,
    output in_ready, out_valid, out_flit, out_busy
  );
endinterface

// File: rtl/router_switch_allocator.sv
// 5x5 wormhole switch allocator for a 4x4 mesh router: XY routing of head flits,
// per-output round-robin grant, packet-long ownership and one output register per port.
module router_switch_allocator #(
  parameter logic [1:0] X_ADDR = 2'd1,
  parameter logic [1:0] Y_ADDR = 2'd1
) (
  input  logic                      clk,
  input  logic                      rst,
  router_switch_allocator_if.slave  bus
);

  localparam int         PORTS  = 5;
  localparam int         DATA_W = 8;
  localparam logic [2:0] P_L    = 3'd0;
  localparam logic [2:0] P_E    = 3'd1;
  localparam logic [2:0] P_N    = 3'd2;
  localparam logic [2:0] P_W    = 3'd3;
  localparam logic [2:0] P_S    = 3'd4;

  typedef enum logic {IDLE, BUSY} state_e;

  // X first, then Y; a smaller y coordinate lies to the north.
  function automatic logic [2:0] route_port(input logic [DATA_W-1:0] flit);
    logic signed [2:0] xdiff;
    logic signed [2:0] ydiff;
    xdiff = $signed({1'b0, flit[3:2]}) - $signed({1'b0, X_ADDR});
    ydiff = $signed({1'b0, flit[1:0]}) - $signed({1'b0, Y_ADDR});
    if (xdiff > 3'sd0)      route_port = P_E;
    else if (xdiff < 3'sd0) route_port = P_W;
    else if (ydiff > 3'sd0) route_port = P_S;
    else if (ydiff < 3'sd0) route_port = P_N;
    else                    route_port = P_L;
  endfunction

  // Returns {found, index}: first set candidate strictly after ptr, wrapping mod 5.
  function automatic logic [3:0] rr_pick(input logic [PORTS-1:0] cand,
                                         input logic [2:0]       ptr);
    logic [2:0] idx;
    rr_pick = '0;
    idx     = ptr;
    for (int k = 0; k < PORTS; k++) begin
      idx = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
      if (cand[idx] && !rr_pick[3]) rr_pick = {1'b1, idx};
    end
  endfunction

  state_e             state_r   [PORTS];
  state_e             state_nxt [PORTS];
  logic [2:0]         owner_r   [PORTS];
  logic [2:0]         owner_nxt [PORTS];
  logic [2:0]         ptr_r     [PORTS];
  logic [2:0]         ptr_nxt   [PORTS];
  logic [DATA_W-1:0]  flit_p1   [PORTS];
  logic [DATA_W-1:0]  flit_nxt  [PORTS];
  logic [PORTS-1:0]   vld_p1;
  logic [PORTS-1:0]   vld_nxt;

  logic [DATA_W-1:0]  in_flit_a [PORTS];
  logic [2:0]         route     [PORTS];
  logic [PORTS-1:0]   is_head;
  logic [PORTS-1:0]   owns_any;
  logic [PORTS-1:0]   busy_vec;
  logic [PORTS-1:0]   in_ready_c;
  logic [PORTS*DATA_W-1:0] out_flit_c;

  // Input decode and ownership summary from the registered allocation state
  always_comb begin
    owns_any   = '0;
    busy_vec   = '0;
    out_flit_c = '0;
    for (int p = 0; p < PORTS; p++) begin
      in_flit_a[p] = bus.in_flit[DATA_W*p +: DATA_W];
      is_head[p]   = bus.in_flit[DATA_W*p + 7];
      route[p]     = route_port(bus.in_flit[DATA_W*p +: DATA_W]);
    end
    for (int o = 0; o < PORTS; o++) begin
      busy_vec[o] = (state_r[o] == BUSY);
      if (state_r[o] == BUSY) owns_any[owner_r[o]] = 1'b1;
      out_flit_c[DATA_W*o +: DATA_W] = flit_p1[o];
    end
  end

  // Per-output allocation FSM and output register next-state
  always_comb begin
    logic [PORTS-1:0]  cand_v;
    logic [3:0]        grant;
    logic              can_acc;
    logic [DATA_W-1:0] src;
    in_ready_c = '0;
    cand_v     = '0;
    grant      = '0;
    can_acc    = 1'b0;
    src        = '0;
    for (int o = 0; o < PORTS; o++) begin
      state_nxt[o] = state_r[o];
      owner_nxt[o] = owner_r[o];
      ptr_nxt[o]   = ptr_r[o];
      vld_nxt[o]   = vld_p1[o];
      flit_nxt[o]  = flit_p1[o];
      cand_v       = '0;
      grant        = '0;
      can_acc      = !vld_p1[o] || bus.out_ready[o];
      src          = in_flit_a[owner_r[o]];
      case (state_r[o])
        IDLE: begin
          if (bus.out_ready[o]) vld_nxt[o] = 1'b0;
          for (int p = 0; p < PORTS; p++) begin
            cand_v[p] = bus.in_valid[p] && is_head[p] &&
                        (route[p] == 3'(o)) && !owns_any[p];
          end
          grant = rr_pick(cand_v, ptr_r[o]);
          if (grant[3]) begin
            state_nxt[o] = BUSY;
            owner_nxt[o] = grant[2:0];
            ptr_nxt[o]   = grant[2:0];
          end
        end
        BUSY: begin
          if (can_acc) begin
            in_ready_c[owner_r[o]] = 1'b1;
            if (bus.in_valid[owner_r[o]]) begin
              vld_nxt[o]  = 1'b1;
              flit_nxt[o] = src;
              // Tail and single-flit types both carry bit 6 set
              if (src[6]) state_nxt[o] = IDLE;
            end else if (bus.out_ready[o]) begin
              vld_nxt[o] = 1'b0;
            end
          end
        end
        default: state_nxt[o] = IDLE;
      endcase
    end
  end

  // Allocation state and output register stage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int o = 0; o < PORTS; o++) begin
        state_r[o] <= IDLE;
        owner_r[o] <= '0;
        ptr_r[o]   <= 3'd4;
        flit_p1[o] <= '0;
      end
      vld_p1 <= '0;
    end else begin
      for (int o = 0; o < PORTS; o++) begin
        state_r[o] <= state_nxt[o];
        owner_r[o] <= owner_nxt[o];
        ptr_r[o]   <= ptr_nxt[o];
        flit_p1[o] <= flit_nxt[o];
      end
      vld_p1 <= vld_nxt;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = vld_p1;
  assign bus.out_flit  = out_flit_c;
  assign bus.out_busy  = busy_vec;

endmodule

// File: tb/tb_router_switch_allocator.sv
// Bench for router_switch_allocator at mesh position (1,1): directed scenarios plus
// randomized packet traffic compared against a cycle-level behavioural model.
module tb_router_switch_allocator;

  localparam int MX = 1;
  localparam int MY = 1;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  router_switch_allocator_if bus();

  router_switch_allocator #(.X_ADDR(2'd1), .Y_ADDR(2'd1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Output port a flit should leave on, from plain coordinate differences.
  function automatic int model_route(input logic [7:0] f);
    int dx = int'(f[3:2]);
    int dy = int'(f[1:0]);
    if (dx > MX) return 1;
    if (dx < MX) return 3;
    if (dy > MY) return 4;
    if (dy < MY) return 2;
    return 0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_valid  = '0;
    bus.in_flit   = '0;
    bus.out_ready = '1;
  endtask

  task automatic set_flit(input int p, input logic [7:0] f);
    bus.in_flit[8*p +: 8] = f;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    #2;
    n_checks++;
    if (bus.out_valid !== 5'b0) $display("FAIL reset_out_valid: got %b expected %b", bus.out_valid, 5'b0);
    else n_pass++;
    n_checks++;
    if (bus.out_busy !== 5'b0) $display("FAIL reset_out_busy: got %b expected %b", bus.out_busy, 5'b0);
    else n_pass++;
    n_checks++;
    if (bus.in_ready !== 5'b0) $display("FAIL reset_in_ready: got %b expected %b", bus.in_ready, 5'b0);
    else n_pass++;
    n_checks++;
    if (bus.out_flit !== 40'h0) $display("FAIL reset_out_flit: got %h expected %h", bus.out_flit, 40'h0);
    else n_pass++;
    @(negedge clk) rst = 1'b1;
    cyc();
  endtask

  task automatic test_single_local();
    idle_inputs();
    bus.in_valid = 5'b00001;
    set_flit(0, 8'hC5);
    #1;
    n_checks++;
    if (bus.out_busy !== 5'b0) $display("FAIL single_pregrant_busy: got %b expected %b", bus.out_busy, 5'b0);
    else n_pass++;
    cyc();
    n_checks++;
    if ({bus.out_busy, bus.in_ready, bus.out_valid} !== {5'b00001, 5'b00001, 5'b0})
      $display("FAIL single_grant: got busy=%b rdy=%b ov=%b expected busy=00001 rdy=00001 ov=00000",
               bus.out_busy, bus.in_ready, bus.out_valid);
    else n_pass++;
    cyc();
    bus.in_valid = '0;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.out_flit[7:0], bus.out_busy} !== {5'b00001, 8'hC5, 5'b0})
      $display("FAIL single_deliver: got ov=%b flit=%h busy=%b expected ov=00001 flit=c5 busy=00000",
               bus.out_valid, bus.out_flit[7:0], bus.out_busy);
    else n_pass++;
    cyc();
    n_checks++;
    if (bus.out_valid !== 5'b0) $display("FAIL single_drain: got %b expected %b", bus.out_valid, 5'b0);
    else n_pass++;
  endtask

  task automatic test_contention();
    idle_inputs();
    bus.in_valid = 5'b01001;
    set_flit(0, 8'h89);
    set_flit(3, 8'h89);
    cyc();
    n_checks++;
    if ({bus.out_busy, bus.in_ready} !== {5'b00010, 5'b00001})
      $display("FAIL contend_first_grant: got busy=%b rdy=%b expected busy=00010 rdy=00001", bus.out_busy, bus.in_ready);
    else n_pass++;
    cyc();
    set_flit(0, 8'h49);
    #1;
    n_checks++;
    if ({bus.out_valid[1], bus.out_flit[15:8], bus.in_ready} !== {1'b1, 8'h89, 5'b00001})
      $display("FAIL contend_l_head: got ov=%b flit=%h rdy=%b expected ov=1 flit=89 rdy=00001",
               bus.out_valid[1], bus.out_flit[15:8], bus.in_ready);
    else n_pass++;
    cyc();
    bus.in_valid = 5'b01000;
    #1;
    n_checks++;
    if ({bus.out_flit[15:8], bus.out_busy, bus.in_ready} !== {8'h49, 5'b0, 5'b0})
      $display("FAIL contend_l_tail: got flit=%h busy=%b rdy=%b expected flit=49 busy=00000 rdy=00000",
               bus.out_flit[15:8], bus.out_busy, bus.in_ready);
    else n_pass++;
    cyc();
    n_checks++;
    if ({bus.out_busy, bus.in_ready} !== {5'b00010, 5'b01000})
      $display("FAIL contend_w_grant: got busy=%b rdy=%b expected busy=00010 rdy=01000", bus.out_busy, bus.in_ready);
    else n_pass++;
    cyc();
    set_flit(3, 8'h49);
    #1;
    n_checks++;
    if (bus.out_flit[15:8] !== 8'h89) $display("FAIL contend_w_head: got %h expected %h", bus.out_flit[15:8], 8'h89);
    else n_pass++;
    cyc();
    bus.in_valid = '0;
    #1;
    n_checks++;
    if ({bus.out_flit[15:8], bus.out_busy} !== {8'h49, 5'b0})
      $display("FAIL contend_w_tail: got flit=%h busy=%b expected flit=49 busy=00000", bus.out_flit[15:8], bus.out_busy);
    else n_pass++;
    cyc();
  endtask

  task automatic test_backpressure();
    idle_inputs();
    // Head destined for (0,0) leaves west from (1,1)
    bus.in_valid = 5'b00100;
    set_flit(2, 8'h80);
    cyc();
    n_checks++;
    if ({bus.out_busy, bus.in_ready} !== {5'b01000, 5'b00100})
      $display("FAIL bp_grant: got busy=%b rdy=%b expected busy=01000 rdy=00100", bus.out_busy, bus.in_ready);
    else n_pass++;
    cyc();
    bus.out_ready = 5'b10111;
    set_flit(2, 8'h00);
    #1;
    n_checks++;
    if ({bus.out_valid[3], bus.out_flit[31:24], bus.in_ready} !== {1'b1, 8'h80, 5'b0})
      $display("FAIL bp_head_stall: got ov=%b flit=%h rdy=%b expected ov=1 flit=80 rdy=00000",
               bus.out_valid[3], bus.out_flit[31:24], bus.in_ready);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if ({bus.out_valid[3], bus.out_flit[31:24], bus.in_ready} !== {1'b1, 8'h80, 5'b0})
        $display("FAIL bp_hold_%0d: got ov=%b flit=%h rdy=%b expected ov=1 flit=80 rdy=00000",
                 i, bus.out_valid[3], bus.out_flit[31:24], bus.in_ready);
      else n_pass++;
    end
    bus.out_ready = '1;
    #1;
    n_checks++;
    if (bus.in_ready !== 5'b00100) $display("FAIL bp_release_rdy: got %b expected %b", bus.in_ready, 5'b00100);
    else n_pass++;
    cyc();
    set_flit(2, 8'h40);
    #1;
    n_checks++;
    if ({bus.out_valid[3], bus.out_flit[31:24], bus.in_ready} !== {1'b1, 8'h00, 5'b00100})
      $display("FAIL bp_body: got ov=%b flit=%h rdy=%b expected ov=1 flit=00 rdy=00100",
               bus.out_valid[3], bus.out_flit[31:24], bus.in_ready);
    else n_pass++;
    cyc();
    bus.in_valid = '0;
    #1;
    n_checks++;
    if ({bus.out_valid[3], bus.out_flit[31:24], bus.out_busy} !== {1'b1, 8'h40, 5'b0})
      $display("FAIL bp_tail: got ov=%b flit=%h busy=%b expected ov=1 flit=40 busy=00000",
               bus.out_valid[3], bus.out_flit[31:24], bus.out_busy);
    else n_pass++;
    cyc();
    n_checks++;
    if (bus.out_valid !== 5'b0) $display("FAIL bp_drain: got %b expected %b", bus.out_valid, 5'b0);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [4:0] exp_rdy;
    do_reset();
    bus.in_valid = 5'b10001;
    set_flit(0, 8'hC9);
    set_flit(4, 8'hC9);
    for (int i = 0; i < 4; i++) begin
      cyc();
      exp_rdy = (i % 2 == 0) ? 5'b00001 : 5'b10000;
      n_checks++;
      if (bus.in_ready !== exp_rdy) $display("FAIL rr_grant_%0d: got %b expected %b", i, bus.in_ready, exp_rdy);
      else n_pass++;
      cyc();
      n_checks++;
      if ({bus.out_valid[1], bus.out_flit[15:8], bus.out_busy} !== {1'b1, 8'hC9, 5'b0})
        $display("FAIL rr_deliver_%0d: got ov=%b flit=%h busy=%b expected ov=1 flit=c9 busy=00000",
                 i, bus.out_valid[1], bus.out_flit[15:8], bus.out_busy);
      else n_pass++;
    end
    bus.in_valid = '0;
    cyc();
    cyc();
  endtask

  task automatic test_orphan_body();
    idle_inputs();
    bus.in_valid = 5'b00010;
    set_flit(1, 8'h00);
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_checks++;
      if ({bus.in_ready, bus.out_busy, bus.out_valid} !== 15'b0)
        $display("FAIL orphan_%0d: got rdy=%b busy=%b ov=%b expected all zero",
                 i, bus.in_ready, bus.out_busy, bus.out_valid);
      else n_pass++;
    end
    idle_inputs();
    cyc();
  endtask

  task automatic test_async_reset();
    idle_inputs();
    bus.out_ready = 5'b11101;
    bus.in_valid  = 5'b00001;
    set_flit(0, 8'h89);
    cyc();
    cyc();
    bus.in_valid = '0;
    #1;
    n_checks++;
    if ({bus.out_valid[1], bus.out_busy[1]} !== 2'b11)
      $display("FAIL areset_pre: got ov=%b busy=%b expected ov=1 busy=1", bus.out_valid[1], bus.out_busy[1]);
    else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.out_busy, bus.in_ready, bus.out_flit} !== 55'b0)
      $display("FAIL areset_clear: got ov=%b busy=%b rdy=%b flit=%h expected all zero",
               bus.out_valid, bus.out_busy, bus.in_ready, bus.out_flit);
    else n_pass++;
    #1 rst = 1'b1;
    bus.out_ready = '1;
    bus.in_valid  = 5'b00001;
    set_flit(0, 8'hC9);
    cyc();
    n_checks++;
    if ({bus.out_busy, bus.in_ready} !== {5'b00010, 5'b00001})
      $display("FAIL areset_realloc: got busy=%b rdy=%b expected busy=00010 rdy=00001", bus.out_busy, bus.in_ready);
    else n_pass++;
    cyc();
    bus.in_valid = '0;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.out_flit[15:8]} !== {5'b00010, 8'hC9})
      $display("FAIL areset_deliver: got ov=%b flit=%h expected ov=00010 flit=c9", bus.out_valid, bus.out_flit[15:8]);
    else n_pass++;
    cyc();
  endtask

  task automatic test_random();
    int         m_owner [5];
    int         m_ptr   [5];
    bit         m_ov    [5];
    logic [7:0] m_of    [5];
    bit         owned   [5];
    logic [7:0] pkt     [5][3];
    logic [7:0] cur     [5];
    int         plen    [5];
    int         ppos    [5];
    logic [4:0] iv, ordy, exp_rdy, exp_ov, exp_busy;
    logic [39:0] exp_of;
    do_reset();
    for (int p = 0; p < 5; p++) begin
      m_owner[p] = -1;
      m_ptr[p]   = 4;
      m_ov[p]    = 1'b0;
      m_of[p]    = 8'h00;
      plen[p]    = 0;
      ppos[p]    = 0;
    end
    for (int c = 0; c < 1500; c++) begin
      for (int p = 0; p < 5; p++) begin
        if (plen[p] == 0 && $urandom_range(0, 2) == 0) begin
          int len;
          logic [3:0] d;
          len = $urandom_range(1, 3);
          d   = 4'($urandom);
          if (len == 1) pkt[p][0] = {2'b11, 2'($urandom), d};
          else begin
            pkt[p][0] = {2'b10, 2'($urandom), d};
            for (int k = 1; k < len - 1; k++) pkt[p][k] = {2'b00, 6'($urandom)};
            pkt[p][len-1] = {2'b01, 6'($urandom)};
          end
          plen[p] = len;
          ppos[p] = 0;
        end
        iv[p]   = (plen[p] != 0) && ($urandom_range(0, 3) != 0);
        cur[p]  = (plen[p] != 0) ? pkt[p][ppos[p]] : 8'($urandom);
        ordy[p] = ($urandom_range(0, 3) != 0);
        set_flit(p, cur[p]);
      end
      bus.in_valid  = iv;
      bus.out_ready = ordy;
      #1;
      exp_rdy  = '0;
      exp_ov   = '0;
      exp_busy = '0;
      exp_of   = '0;
      for (int o = 0; o < 5; o++) begin
        exp_ov[o]         = m_ov[o];
        exp_busy[o]       = (m_owner[o] >= 0);
        exp_of[8*o +: 8]  = m_of[o];
        if (m_owner[o] >= 0 && (!m_ov[o] || ordy[o])) exp_rdy[m_owner[o]] = 1'b1;
      end
      n_checks++;
      if (bus.in_ready !== exp_rdy) $display("FAIL rand_in_ready cyc=%0d: got %b expected %b", c, bus.in_ready, exp_rdy);
      else n_pass++;
      n_checks++;
      if (bus.out_valid !== exp_ov) $display("FAIL rand_out_valid cyc=%0d: got %b expected %b", c, bus.out_valid, exp_ov);
      else n_pass++;
      n_checks++;
      if (bus.out_flit !== exp_of) $display("FAIL rand_out_flit cyc=%0d: got %h expected %h", c, bus.out_flit, exp_of);
      else n_pass++;
      n_checks++;
      if (bus.out_busy !== exp_busy) $display("FAIL rand_out_busy cyc=%0d: got %b expected %b", c, bus.out_busy, exp_busy);
      else n_pass++;
      // Model the clock edge: ownership is judged as it stood before the edge
      for (int p = 0; p < 5; p++) owned[p] = 1'b0;
      for (int o = 0; o < 5; o++) if (m_owner[o] >= 0) owned[m_owner[o]] = 1'b1;
      for (int o = 0; o < 5; o++) begin
        if (m_owner[o] >= 0) begin
          int src;
          src = m_owner[o];
          if (iv[src] && (!m_ov[o] || ordy[o])) begin
            m_of[o] = cur[src];
            m_ov[o] = 1'b1;
            if (cur[src][7:6] == 2'b01 || cur[src][7:6] == 2'b11) m_owner[o] = -1;
          end else if (ordy[o]) m_ov[o] = 1'b0;
        end else begin
          bit found;
          found = 1'b0;
          if (ordy[o]) m_ov[o] = 1'b0;
          for (int k = 1; k <= 5; k++) begin
            int p;
            p = (m_ptr[o] + k) % 5;
            if (!found && iv[p] && cur[p][7] && model_route(cur[p]) == o && !owned[p]) begin
              m_owner[o] = p;
              m_ptr[o]   = p;
              found      = 1'b1;
            end
          end
        end
      end
      for (int p = 0; p < 5; p++) begin
        if (iv[p] && exp_rdy[p]) begin
          ppos[p]++;
          if (ppos[p] == plen[p]) begin
            plen[p] = 0;
            ppos[p] = 0;
          end
        end
      end
      cyc();
    end
    idle_inputs();
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_local();
    test_contention();
    test_backpressure();
    test_round_robin();
    test_orphan_body();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
